dice_roll_ctrl: RTL and testbench

Sequences one dice roll for the dice simulator. It detects a press on the centre button, runs a timed "rolling" animation that keeps refreshing the displayed face, then freezes a final face in the range 1..N for the selected die. It outputs the face as binary and as BCD digits, which feed directly into the 7-segment display path. It sits between the die selector (which supplies Dice_Sel) and the digit separator/display stage.

---
 rtl/dice_pkg.sv | 33 +++
 rtl/bin_to_bcd100.sv | 24 ++
 rtl/dice_roll_ctrl.sv | 121 ++++++++++++
 tb/tb_dice_roll_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dice_pkg.sv
// Shared definitions for the dice roll controller: die codes, face counts and FSM states.
package dice_pkg;

  localparam logic [2:0] DIE_D4     = 3'd0;
  localparam logic [2:0] DIE_D6     = 3'd1;
  localparam logic [2:0] DIE_D8     = 3'd2;
  localparam logic [2:0] DIE_D10    = 3'd3;
  localparam logic [2:0] DIE_D12    = 3'd4;
  localparam logic [2:0] DIE_D20    = 3'd5;
  localparam logic [2:0] DIE_D100   = 3'd6;
  localparam logic [2:0] DIE_D6_ALT = 3'd7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROLLING = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // Number of faces for a die code; the spare code 7 behaves as a d6.
  function automatic logic [6:0] face_count(input logic [2:0] code);
    case (code)
      DIE_D4:              return 7'd4;
      DIE_D6, DIE_D6_ALT:  return 7'd6;
      DIE_D8:              return 7'd8;
      DIE_D10:             return 7'd10;
      DIE_D12:             return 7'd12;
      DIE_D20:             return 7'd20;
      DIE_D100:            return 7'd100;
      default:             return 7'd6;
    endcase
  endfunction

endpackage

// File: rtl/bin_to_bcd100.sv
// Combinational 7-bit binary to three-digit BCD for values 0..100.
module bin_to_bcd100 (
  input  logic [6:0] bin,
  output logic [3:0] unit,
  output logic [3:0] diz,
  output logic [3:0] cent
);

  logic [6:0] rem;

  // Strip the hundreds digit (only ever 0 or 1), then split tens and units.
  always_comb begin
    if (bin >= 7'd100) begin
      cent = 4'd1;
      rem  = bin - 7'd100;
    end else begin
      cent = 4'd0;
      rem  = bin;
    end
    diz  = 4'(rem / 7'd10);
    unit = 4'(rem % 7'd10);
  end

endmodule

// File: rtl/dice_roll_ctrl.sv
// Dice roll sequencer: press edge starts a timed rolling animation, then a
// final face 1..N is frozen and presented as binary and BCD.
module dice_roll_ctrl
  import dice_pkg::*;
#(
  parameter int ROLL_CYCLES = 50_000_000,
  parameter int ANIM_DIV    = 2_500_000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Roll_Btn,
  input  logic [2:0] Dice_Sel,
  output logic [6:0] Value,
  output logic [3:0] Bcd_Unit,
  output logic [3:0] Bcd_Diz,
  output logic [3:0] Bcd_Cent,
  output logic       Rolling,
  output logic       Valid,
  output logic [7:0] Roll_Count
);

  localparam int TW = $clog2(ROLL_CYCLES);
  localparam int DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(ROLL_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(ANIM_DIV - 1);

  state_t        state, state_next;
  logic          btn_prev;
  logic          press;
  logic [2:0]    sel_lat, sel_lat_next;
  logic [6:0]    face, face_next, n_cur;
  logic [6:0]    value_next;
  logic [TW-1:0] timer, timer_next;
  logic [DW-1:0] divider, div_next;
  logic [7:0]    count_next;
  logic [3:0]    unit_next, diz_next, cent_next;

  assign press   = Roll_Btn & ~btn_prev;
  assign Rolling = (state == ROLLING);
  assign Valid   = (state == HOLD);

  // The die is frozen while rolling so a selector change cannot skew the result.
  assign n_cur     = (state == ROLLING) ? face_count(sel_lat) : face_count(Dice_Sel);
  assign face_next = (face >= n_cur) ? 7'd1 : face + 7'd1;

  // BCD is derived from the next Value so both registers always agree.
  bin_to_bcd100 u_bcd (
    .bin  (value_next),
    .unit (unit_next),
    .diz  (diz_next),
    .cent (cent_next)
  );

  // Next-state logic: press handling, animation refresh, final sample and HOLD exits.
  always_comb begin
    state_next   = state;
    value_next   = Value;
    sel_lat_next = sel_lat;
    timer_next   = timer;
    div_next     = divider;
    count_next   = Roll_Count;
    case (state)
      IDLE, HOLD: begin
        if (press) begin
          sel_lat_next = Dice_Sel;
          timer_next   = '0;
          div_next     = '0;
          state_next   = ROLLING;
        end else if (state == HOLD && Dice_Sel != sel_lat) begin
          value_next = 7'd0;
          state_next = IDLE;
        end
      end
      ROLLING: begin
        timer_next = timer + TW'(1);
        if (divider == DIV_LAST) begin
          value_next = face;
          div_next   = '0;
        end else begin
          div_next = divider + DW'(1);
        end
        if (timer == TIMER_LAST) begin
          value_next = face;
          count_next = Roll_Count + 8'd1;
          state_next = HOLD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers; reset abandons any roll in progress.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      btn_prev   <= 1'b0;
      sel_lat    <= 3'd0;
      face       <= 7'd1;
      timer      <= '0;
      divider    <= '0;
      Value      <= 7'd0;
      Bcd_Unit   <= 4'd0;
      Bcd_Diz    <= 4'd0;
      Bcd_Cent   <= 4'd0;
      Roll_Count <= 8'd0;
    end else begin
      state      <= state_next;
      btn_prev   <= Roll_Btn;
      sel_lat    <= sel_lat_next;
      face       <= face_next;
      timer      <= timer_next;
      divider    <= div_next;
      Value      <= value_next;
      Bcd_Unit   <= unit_next;
      Bcd_Diz    <= diz_next;
      Bcd_Cent   <= cent_next;
      Roll_Count <= count_next;
    end
  end

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Bench for dice_roll_ctrl: instance a (ROLL_CYCLES=8, ANIM_DIV=2) and
// instance b (ROLL_CYCLES=9, ANIM_DIV=2) share clock and inputs.
module tb_dice_roll_ctrl;

  logic       Clk, Rst, Roll_Btn;
  logic [2:0] Dice_Sel;
  logic [6:0] a_value, b_value;
  logic [3:0] a_unit, a_diz, a_cent, b_unit, b_diz, b_cent;
  logic       a_rolling, a_valid, b_rolling, b_valid;
  logic [7:0] a_count, b_count;

  typedef struct {
    int lo;
    int hi;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  dice_roll_ctrl #(.ROLL_CYCLES(8), .ANIM_DIV(2)) dut_a (
    .Clk(Clk), .Rst(Rst), .Roll_Btn(Roll_Btn), .Dice_Sel(Dice_Sel),
    .Value(a_value), .Bcd_Unit(a_unit), .Bcd_Diz(a_diz), .Bcd_Cent(a_cent),
    .Rolling(a_rolling), .Valid(a_valid), .Roll_Count(a_count)
  );

  dice_roll_ctrl #(.ROLL_CYCLES(9), .ANIM_DIV(2)) dut_b (
    .Clk(Clk), .Rst(Rst), .Roll_Btn(Roll_Btn), .Dice_Sel(Dice_Sel),
    .Value(b_value), .Bcd_Unit(b_unit), .Bcd_Diz(b_diz), .Bcd_Cent(b_cent),
    .Rolling(b_rolling), .Valid(b_valid), .Roll_Count(b_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic int face_at(input int c, input int n);
    return (c % n) + 1;
  endfunction

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic expect_range(input int lo, input int hi);
    exp_t e;
    e.lo = lo;
    e.hi = hi;
    exp_q.push_back(e);
  endtask

  // Three reset cycles with the button held, then release; leaves the bench in cycle 0.
  task automatic do_reset(input logic [2:0] sel);
    Dice_Sel = sel;
    Rst      = 1'b1;
    Roll_Btn = 1'b1;
    repeat (3) step();
    Rst      = 1'b0;
    Roll_Btn = 1'b0;
    cyc      = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset(3'd1);
    checks++;
    if ({a_value, a_unit, a_diz, a_cent, a_rolling, a_valid, a_count} !== 29'd0)
      begin errors++; $display("FAIL reset_a: got value=%0d unit=%0d diz=%0d cent=%0d rolling=%b valid=%b count=%0d, required all 0",
        a_value, a_unit, a_diz, a_cent, a_rolling, a_valid, a_count); end
    checks++;
    if ({b_value, b_unit, b_diz, b_cent, b_rolling, b_valid, b_count} !== 29'd0)
      begin errors++; $display("FAIL reset_b: got value=%0d rolling=%b valid=%b count=%0d, required all 0",
        b_value, b_rolling, b_valid, b_count); end
    step();
    checks++;
    if (a_rolling !== 1'b0) begin errors++; $display("FAIL no_roll_after_release: cycle %0d rolling=%b required 0", cyc, a_rolling); end
    step();
    checks++;
    if (a_rolling !== 1'b0 || a_valid !== 1'b0) begin errors++; $display("FAIL idle_after_release: cycle %0d rolling=%b valid=%b required 0 0", cyc, a_rolling, a_valid); end
  endtask

  task automatic test_d6_roll();
    exp_t e;
    do_reset(3'd1);
    repeat (3) step();
    Roll_Btn = 1'b1;
    expect_range(face_at(3 + 8, 6), face_at(3 + 8, 6));
    checks++;
    if (a_rolling !== 1'b0) begin errors++; $display("FAIL d6_press_cycle: rolling=%b required 0", a_rolling); end
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (a_rolling !== 1'b1 || a_valid !== 1'b0)
        begin errors++; $display("FAIL d6_rolling: cycle %0d rolling=%b valid=%b required 1 0", cyc, a_rolling, a_valid); end
    end
    step();
    checks++;
    if (a_valid !== 1'b1 || a_rolling !== 1'b0)
      begin errors++; $display("FAIL d6_done: cycle %0d valid=%b rolling=%b required 1 0", cyc, a_valid, a_rolling); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL d6_value: nothing expected, got %0d", a_value); end
    else begin
      e = exp_q.pop_front();
      if (int'(a_value) < e.lo || int'(a_value) > e.hi)
        begin errors++; $display("FAIL d6_value: got %0d required %0d..%0d", a_value, e.lo, e.hi); end
    end
    checks++;
    if (a_count !== 8'd1) begin errors++; $display("FAIL d6_count: got %0d required 1", a_count); end
    checks++;
    if (a_unit !== 4'd6 || a_diz !== 4'd0 || a_cent !== 4'd0)
      begin errors++; $display("FAIL d6_bcd: got %0d%0d%0d required 006", a_cent, a_diz, a_unit); end
    Roll_Btn = 1'b0;
  endtask

  task automatic test_d100_boundary();
    exp_t e;
    do_reset(3'd6);
    repeat (90) step();
    Roll_Btn = 1'b1;
    expect_range(face_at(90 + 9, 100), face_at(90 + 9, 100));
    for (int k = 0; k < 9; k++) begin
      step();
      Roll_Btn = 1'b0;
      checks++;
      if (b_rolling !== 1'b1 || b_valid !== 1'b0)
        begin errors++; $display("FAIL d100_rolling: cycle %0d rolling=%b valid=%b required 1 0", cyc, b_rolling, b_valid); end
    end
    step();
    checks++;
    if (b_valid !== 1'b1) begin errors++; $display("FAIL d100_valid: cycle %0d valid=%b required 1", cyc, b_valid); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL d100_value: nothing expected, got %0d", b_value); end
    else begin
      e = exp_q.pop_front();
      if (int'(b_value) < e.lo || int'(b_value) > e.hi)
        begin errors++; $display("FAIL d100_value: got %0d required %0d..%0d", b_value, e.lo, e.hi); end
    end
    checks++;
    if (b_cent !== 4'd1 || b_diz !== 4'd0 || b_unit !== 4'd0)
      begin errors++; $display("FAIL d100_bcd: got %0d%0d%0d required 100", b_cent, b_diz, b_unit); end
  endtask

  task automatic test_ignored_inputs();
    exp_t e;
    do_reset(3'd1);
    repeat (3) step();
    Roll_Btn = 1'b1;
    expect_range(1, 6);
    for (int k = 0; k < 8; k++) begin
      step();
      if (cyc == 5) Roll_Btn = 1'b0;
      if (cyc == 6) Dice_Sel = 3'd0;
      if (cyc == 7) Roll_Btn = 1'b1;
      checks++;
      if (a_rolling !== 1'b1 || a_valid !== 1'b0 || a_value > 7'd6)
        begin errors++; $display("FAIL ign_rolling: cycle %0d rolling=%b valid=%b value=%0d required 1 0 <=6", cyc, a_rolling, a_valid, a_value); end
    end
    step();
    checks++;
    if (a_valid !== 1'b1 || a_count !== 8'd1)
      begin errors++; $display("FAIL ign_length: cycle %0d valid=%b count=%0d required 1 1", cyc, a_valid, a_count); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL ign_value: nothing expected, got %0d", a_value); end
    else begin
      e = exp_q.pop_front();
      if (int'(a_value) < e.lo || int'(a_value) > e.hi)
        begin errors++; $display("FAIL ign_value: got %0d required %0d..%0d", a_value, e.lo, e.hi); end
    end
    // Selector now differs from the latched die, so HOLD is left immediately.
    step();
    checks++;
    if (a_value !== 7'd0 || a_valid !== 1'b0 || a_rolling !== 1'b0)
      begin errors++; $display("FAIL ign_hold_clear: value=%0d valid=%b rolling=%b required 0 0 0", a_value, a_valid, a_rolling); end
    Roll_Btn = 1'b0;
  endtask

  task automatic test_hold_exits();
    exp_t e;
    int   n;
    do_reset(3'd1);
    repeat (3) step();
    Roll_Btn = 1'b1;
    expect_range(1, 6);
    step();
    Roll_Btn = 1'b0;
    repeat (8) step();
    checks++;
    if (exp_q.size() == 0 || a_valid !== 1'b1) begin errors++; $display("FAIL hold_first: valid=%b queue=%0d required 1 1", a_valid, exp_q.size()); end
    else begin
      e = exp_q.pop_front();
      if (int'(a_value) < e.lo || int'(a_value) > e.hi)
        begin errors++; $display("FAIL hold_first: got %0d required %0d..%0d", a_value, e.lo, e.hi); end
    end
    // Press and selector change together: the press wins.
    Roll_Btn = 1'b1;
    Dice_Sel = 3'd2;
    expect_range(1, 8);
    step();
    Roll_Btn = 1'b0;
    checks++;
    if (a_rolling !== 1'b1 || a_valid !== 1'b0)
      begin errors++; $display("FAIL hold_press_wins: rolling=%b valid=%b required 1 0", a_rolling, a_valid); end
    n = 0;
    while (a_valid !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (a_valid !== 1'b1 || cyc != 21)
      begin errors++; $display("FAIL hold_second_done: valid=%b at cycle %0d required 1 at 21", a_valid, cyc); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL hold_second_value: nothing expected, got %0d", a_value); end
    else begin
      e = exp_q.pop_front();
      if (int'(a_value) < e.lo || int'(a_value) > e.hi || a_count !== 8'd2)
        begin errors++; $display("FAIL hold_second_value: got %0d count %0d required %0d..%0d count 2", a_value, a_count, e.lo, e.hi); end
    end
    Dice_Sel = 3'd3;
    step();
    checks++;
    if (a_value !== 7'd0 || a_valid !== 1'b0 || a_rolling !== 1'b0 || {a_cent, a_diz, a_unit} !== 12'd0)
      begin errors++; $display("FAIL hold_sel_change: value=%0d valid=%b rolling=%b bcd=%0d%0d%0d required 0 0 0 000",
        a_value, a_valid, a_rolling, a_cent, a_diz, a_unit); end
    Dice_Sel = 3'd4;
    step();
    checks++;
    if (a_value !== 7'd0 || a_valid !== 1'b0 || a_rolling !== 1'b0)
      begin errors++; $display("FAIL idle_sel_change: value=%0d valid=%b rolling=%b required 0 0 0", a_value, a_valid, a_rolling); end
  endtask

  task automatic test_reset_mid_roll();
    do_reset(3'd1);
    repeat (3) step();
    Roll_Btn = 1'b1;
    repeat (4) step();
    checks++;
    if (a_rolling !== 1'b1) begin errors++; $display("FAIL midroll_pre: rolling=%b required 1", a_rolling); end
    Rst = 1'b1;
    step();
    checks++;
    if ({a_value, a_unit, a_diz, a_cent, a_rolling, a_valid, a_count} !== 29'd0)
      begin errors++; $display("FAIL midroll_reset: value=%0d rolling=%b valid=%b count=%0d required all 0", a_value, a_rolling, a_valid, a_count); end
    Rst = 1'b0;
    Roll_Btn = 1'b0;
  endtask

  task automatic test_back_to_back_wrap();
    exp_t e;
    int   n;
    do_reset(3'd0);
    step();
    for (int i = 0; i < 256; i++) begin
      Roll_Btn = 1'b1;
      expect_range(1, 4);
      step();
      Roll_Btn = 1'b0;
      n = 0;
      while (a_valid !== 1'b1 && n < 20) begin step(); n++; end
      checks++;
      if (a_valid !== 1'b1) begin
        errors++;
        $display("FAIL wrap_timeout: roll %0d valid=%b required 1", i, a_valid);
        exp_q.delete();
        break;
      end
      checks++;
      e = exp_q.pop_front();
      if (int'(a_value) < e.lo || int'(a_value) > e.hi || a_unit !== a_value[3:0])
        begin errors++; $display("FAIL wrap_value: roll %0d got %0d unit %0d required %0d..%0d", i, a_value, a_unit, e.lo, e.hi); end
      if (i == 254) begin
        checks++;
        if (a_count !== 8'd255) begin errors++; $display("FAIL count_255: got %0d required 255", a_count); end
      end
    end
    checks++;
    if (a_count !== 8'd0) begin errors++; $display("FAIL count_wrap: got %0d required 0", a_count); end
  endtask

  initial begin
    Rst      = 1'b1;
    Roll_Btn = 1'b0;
    Dice_Sel = 3'd1;
    test_reset();
    test_d6_roll();
    test_d100_boundary();
    test_ignored_inputs();
    test_hold_exits();
    test_reset_mid_roll();
    test_back_to_back_wrap();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drained: %0d left required 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
